// File: rtl/frame_result_packer.sv
// Captures a 64-sample frame plus the top-3 sort results and streams them out as one byte packet.
// Optional trailing XOR checksum byte is enabled by defining FRAME_PACK_CSUM_EN.
module frame_result_packer #(
    parameter int DATA_SIZE   = 4,
    parameter int LENGTH      = 64,
    parameter int LENGTH_SIZE = 6
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [DATA_SIZE-1:0]   FramData_i,
    input  logic [LENGTH_SIZE-1:0] FramAdd_i,
    input  logic                   FramEn_i,
    input  logic                   SortValid_i,
    input  logic [DATA_SIZE-1:0]   MaxCountData1_i,
    input  logic [DATA_SIZE-1:0]   MaxCountData2_i,
    input  logic [DATA_SIZE-1:0]   MaxCountData3_i,
    input  logic [LENGTH_SIZE-1:0] MaxCount1_i,
    input  logic [LENGTH_SIZE-1:0] MaxCount2_i,
    input  logic [LENGTH_SIZE-1:0] MaxCount3_i,
    output logic [7:0]             OutData_o,
    output logic                   OutValid_o,
    input  logic                   OutReady_i,
    output logic                   OutLast_o,
    output logic                   Busy_o,
    output logic                   Overrun_o
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_HDR   = 3'd1;
    localparam logic [2:0] S_FRAME = 3'd2;
    localparam logic [2:0] S_RES   = 3'd3;
`ifdef FRAME_PACK_CSUM_EN
    localparam logic [2:0] S_CSUM  = 3'd4;
    localparam int PKT_LEN = LENGTH / 2 + 8;
`else
    localparam int PKT_LEN = LENGTH / 2 + 7;
`endif
    localparam int FRAME_BYTES = LENGTH / 2;
    localparam int RES_FIRST   = FRAME_BYTES + 1;
    localparam int IDX_W       = $clog2(PKT_LEN);

    logic [2:0]             state_q, state_d, nextState;
    logic [IDX_W-1:0]       byteIdx_q, byteIdx_d, nextIdx;
    logic [7:0]             outData_q, outData_d, nextByte;
    logic                   outValid_q, outValid_d;
    logic                   outLast_q, outLast_d;
    logic                   busy_q, busy_d;
    logic                   overrun_q, overrun_d;
    logic                   frameDone_q, frameDone_d;
    logic                   sortDone_q, sortDone_d;
    logic [DATA_SIZE-1:0]   maxData_q [3];
    logic [DATA_SIZE-1:0]   maxData_d [3];
    logic [LENGTH_SIZE-1:0] maxCount_q [3];
    logic [LENGTH_SIZE-1:0] maxCount_d [3];
    logic [DATA_SIZE-1:0]   frameBuf_q [LENGTH];
    logic [LENGTH_SIZE-2:0] pairIdx;
    logic [2:0]             resOff;
    logic                   transfer;
`ifdef FRAME_PACK_CSUM_EN
    logic [7:0]             csum_q, csum_d;
`endif

    // Frame buffer keeps its contents across reset; only IDLE writes land.
    always_ff @(posedge clk_i) begin
        if (!rst_i && state_q == S_IDLE && FramEn_i) begin
            frameBuf_q[FramAdd_i] <= FramData_i;
        end
    end

    // Byte that follows the one currently presented, looked up from its packet index.
    always_comb begin
        nextIdx   = byteIdx_q + 1'b1;
        pairIdx   = byteIdx_q[LENGTH_SIZE-2:0];
        resOff    = 3'(nextIdx - IDX_W'(RES_FIRST));
        nextByte  = 8'h00;
        nextState = S_IDLE;
        if (nextIdx <= IDX_W'(FRAME_BYTES)) begin
            nextByte  = {frameBuf_q[{pairIdx, 1'b1}], frameBuf_q[{pairIdx, 1'b0}]};
            nextState = S_FRAME;
        end else if (nextIdx < IDX_W'(RES_FIRST + 6)) begin
            nextState = S_RES;
            if (resOff[0]) begin
                nextByte = 8'(maxCount_q[resOff[2:1]]);
            end else begin
                nextByte = 8'(maxData_q[resOff[2:1]]);
            end
        end
`ifdef FRAME_PACK_CSUM_EN
        else begin
            nextByte  = csum_q ^ outData_q;
            nextState = S_CSUM;
        end
`endif
    end

    always_comb begin
        transfer    = outValid_q && OutReady_i;
        state_d     = state_q;
        byteIdx_d   = byteIdx_q;
        outData_d   = outData_q;
        outValid_d  = outValid_q;
        outLast_d   = outLast_q;
        frameDone_d = frameDone_q;
        sortDone_d  = sortDone_q;
        maxData_d   = maxData_q;
        maxCount_d  = maxCount_q;
`ifdef FRAME_PACK_CSUM_EN
        csum_d      = csum_q;
`endif
        overrun_d   = (state_q != S_IDLE) && (FramEn_i || SortValid_i);

        if (state_q == S_IDLE) begin
            if (FramEn_i && FramAdd_i == LENGTH_SIZE'(LENGTH - 1)) begin
                frameDone_d = 1'b1;
            end
            if (SortValid_i) begin
                maxData_d[0]  = MaxCountData1_i;
                maxData_d[1]  = MaxCountData2_i;
                maxData_d[2]  = MaxCountData3_i;
                maxCount_d[0] = MaxCount1_i;
                maxCount_d[1] = MaxCount2_i;
                maxCount_d[2] = MaxCount3_i;
                sortDone_d    = 1'b1;
            end
            if (frameDone_q && sortDone_q) begin
                state_d    = S_HDR;
                byteIdx_d  = '0;
                outData_d  = 8'hA5;
                outValid_d = 1'b1;
                outLast_d  = 1'b0;
`ifdef FRAME_PACK_CSUM_EN
                csum_d     = 8'h00;
`endif
            end
        end else if (transfer) begin
`ifdef FRAME_PACK_CSUM_EN
            csum_d = csum_q ^ outData_q;
`endif
            if (outLast_q) begin
                state_d     = S_IDLE;
                outValid_d  = 1'b0;
                outLast_d   = 1'b0;
                frameDone_d = 1'b0;
                sortDone_d  = 1'b0;
            end else begin
                state_d   = nextState;
                byteIdx_d = nextIdx;
                outData_d = nextByte;
                outLast_d = (nextIdx == IDX_W'(PKT_LEN - 1));
            end
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            byteIdx_q   <= '0;
            outData_q   <= 8'h00;
            outValid_q  <= 1'b0;
            outLast_q   <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
            frameDone_q <= 1'b0;
            sortDone_q  <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                maxData_q[i]  <= '0;
                maxCount_q[i] <= '0;
            end
`ifdef FRAME_PACK_CSUM_EN
            csum_q      <= 8'h00;
`endif
        end else begin
            state_q     <= state_d;
            byteIdx_q   <= byteIdx_d;
            outData_q   <= outData_d;
            outValid_q  <= outValid_d;
            outLast_q   <= outLast_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
            frameDone_q <= frameDone_d;
            sortDone_q  <= sortDone_d;
            maxData_q   <= maxData_d;
            maxCount_q  <= maxCount_d;
`ifdef FRAME_PACK_CSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    assign OutData_o  = outData_q;
    assign OutValid_o = outValid_q;
    assign OutLast_o  = outLast_q;
    assign Busy_o     = busy_q;
    assign Overrun_o  = overrun_q;

endmodule

// File: tb/tb_frame_result_packer.sv
// Self-checking bench for frame_result_packer: packet-level reference model plus literal pins.
// Honours FRAME_PACK_CSUM_EN for the expected packet length and checksum byte.
module tb_frame_result_packer;

    localparam int DATA_SIZE   = 4;
    localparam int LENGTH      = 64;
    localparam int LENGTH_SIZE = 6;
`ifdef FRAME_PACK_CSUM_EN
    localparam int PKT_LEN = LENGTH / 2 + 8;
`else
    localparam int PKT_LEN = LENGTH / 2 + 7;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] FramData = '0;
    logic [5:0] FramAdd = '0;
    logic       FramEn = 1'b0;
    logic       SortValid = 1'b0;
    logic [3:0] sd1 = '0, sd2 = '0, sd3 = '0;
    logic [5:0] sc1 = '0, sc2 = '0, sc3 = '0;
    logic [7:0] OutData;
    logic       OutValid, OutLast, Busy, Overrun;
    logic       OutReady = 1'b1;

    always #5 clk = ~clk;

    frame_result_packer #(.DATA_SIZE(DATA_SIZE), .LENGTH(LENGTH), .LENGTH_SIZE(LENGTH_SIZE)) dut (
        .clk_i(clk), .rst_i(rst),
        .FramData_i(FramData), .FramAdd_i(FramAdd), .FramEn_i(FramEn),
        .SortValid_i(SortValid),
        .MaxCountData1_i(sd1), .MaxCountData2_i(sd2), .MaxCountData3_i(sd3),
        .MaxCount1_i(sc1), .MaxCount2_i(sc2), .MaxCount3_i(sc3),
        .OutData_o(OutData), .OutValid_o(OutValid), .OutReady_i(OutReady),
        .OutLast_o(OutLast), .Busy_o(Busy), .Overrun_o(Overrun)
    );

    int checks = 0;
    int fails = 0;
    int cycle = 0;
    int tickCnt = 0;
    int readyMode = 0;
    int ovCount = 0;

    logic [3:0] mBuf [LENGTH];
    logic [3:0] mData [3];
    logic [5:0] mCnt [3];
    logic [7:0] mPkt [PKT_LEN];
    bit   mFrameDone = 0, mSortDone = 0, mBusy = 0, checking = 0, mStart = 0;
    int   mPos = 0;
    int   pktDone = 0;
    logic eValid = 0, eLast = 0, eBusy = 0, eOverrun = 0;
    logic [7:0] eData = '0;
    logic [7:0] logB [$];
    int   logCyc [$];

    function automatic void buildPacket();
        logic [7:0] x;
        mPkt[0] = 8'hA5;
        for (int k = 0; k < LENGTH / 2; k++) mPkt[k + 1] = {mBuf[2 * k + 1], mBuf[2 * k]};
        for (int r = 0; r < 3; r++) begin
            mPkt[LENGTH / 2 + 1 + 2 * r] = {4'h0, mData[r]};
            mPkt[LENGTH / 2 + 2 + 2 * r] = {2'b00, mCnt[r]};
        end
        x = 8'h00;
        for (int i = 0; i < LENGTH / 2 + 7; i++) x = x ^ mPkt[i];
        if (PKT_LEN > LENGTH / 2 + 7) mPkt[PKT_LEN - 1] = x;
    endfunction

    // Packet-level model: decides at each edge what the outputs must show afterwards.
    always @(posedge clk) begin
        cycle++;
        if (OutValid && OutReady) begin
            logB.push_back(OutData);
            logCyc.push_back(cycle);
        end
        if (rst) begin
            checking = 1; mFrameDone = 0; mSortDone = 0; mBusy = 0;
            eValid = 0; eLast = 0; eBusy = 0; eOverrun = 0; eData = 8'h00;
        end else begin
            mStart   = !mBusy && mFrameDone && mSortDone;
            eOverrun = mBusy && (FramEn || SortValid);
            if (!mBusy) begin
                if (FramEn) begin
                    mBuf[FramAdd] = FramData;
                    if (FramAdd == 6'd63) mFrameDone = 1;
                end
                if (SortValid) begin
                    mData[0] = sd1; mData[1] = sd2; mData[2] = sd3;
                    mCnt[0] = sc1; mCnt[1] = sc2; mCnt[2] = sc3;
                    mSortDone = 1;
                end
            end
            if (mStart) begin
                buildPacket();
                mBusy = 1; mPos = 0; eValid = 1; eData = mPkt[0]; eLast = 0; eBusy = 1;
            end else if (mBusy && eValid && OutReady) begin
                if (mPos == PKT_LEN - 1) begin
                    mBusy = 0; eValid = 0; eLast = 0; eBusy = 0;
                    mFrameDone = 0; mSortDone = 0; pktDone++;
                end else begin
                    mPos++;
                    eData = mPkt[mPos];
                    eLast = (mPos == PKT_LEN - 1);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cycle, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            if (Overrun) ovCount++;
            checkOutput("OutValid", 8'(OutValid), 8'(eValid));
            checkOutput("Busy", 8'(Busy), 8'(eBusy));
            checkOutput("Overrun", 8'(Overrun), 8'(eOverrun));
            if (eValid) begin
                checkOutput("OutData", OutData, eData);
                checkOutput("OutLast", 8'(OutLast), 8'(eLast));
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        tickCnt++;
        case (readyMode)
            0: OutReady = 1'b1;
            1: OutReady = (tickCnt % 4 == 0) || (tickCnt % 4 == 3);
            default: OutReady = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic applyStimulus(input logic fe, input logic [5:0] addr, input logic [3:0] data, input logic sv);
        FramEn = fe; FramAdd = addr; FramData = data; SortValid = sv;
        tick();
        FramEn = 1'b0; SortValid = 1'b0;
    endtask

    task automatic setSort(input logic [3:0] d1, input logic [5:0] c1, input logic [3:0] d2,
                           input logic [5:0] c2, input logic [3:0] d3, input logic [5:0] c3);
        sd1 = d1; sc1 = c1; sd2 = d2; sc2 = c2; sd3 = d3; sc3 = c3;
    endtask

    task automatic writeFrame(input bit randomData, input bit lastWithSort);
        logic [5:0] a;
        for (int i = 0; i < LENGTH; i++) begin
            a = 6'(i);
            applyStimulus(1'b1, a, randomData ? 4'($urandom_range(0, 15)) : a[3:0],
                          lastWithSort && (i == LENGTH - 1));
        end
    endtask

    task automatic waitPacket(input bit inject);
        int base;
        bit done;
        base = pktDone;
        done = 0;
        for (int i = 0; i < 600 && !done; i++) begin
            if (inject && $urandom_range(0, 15) == 0) begin
                FramEn = 1'b1; FramAdd = 6'($urandom_range(0, 62)); FramData = 4'($urandom_range(0, 15));
            end
            tick();
            FramEn = 1'b0;
            if (pktDone > base) done = 1;
        end
        checks++;
        if (!done) begin
            fails++;
            $display("[TB] FAIL packet_timeout: got no packet end, expected one within 600 cycles");
        end
    endtask

    initial begin
        tick(); tick(); tick();
        rst = 1'b0;
        tick();
        checkOutput("rst_data", OutData, 8'h00);
        checkOutput("rst_valid", 8'(OutValid), 8'h00);
        checkOutput("rst_last", 8'(OutLast), 8'h00);

        // Directed packet with the known pattern and back-to-back output.
        readyMode = 0;
        logB.delete(); logCyc.delete();
        writeFrame(0, 0);
        setSort(4'd3, 6'd9, 4'd7, 6'd5, 4'd1, 6'd2);
        applyStimulus(1'b0, 6'd0, 4'd0, 1'b1);
        waitPacket(0);
        checkOutput("t1_len", 8'(logB.size()), 8'(PKT_LEN));
        if (logB.size() == PKT_LEN) begin
            checkOutput("t1_b0", logB[0], 8'hA5);
            checkOutput("t1_b1", logB[1], 8'h10);
            checkOutput("t1_b2", logB[2], 8'h32);
            checkOutput("t1_b8", logB[8], 8'hFE);
            checkOutput("t1_b32", logB[32], 8'hFE);
            checkOutput("t1_b33", logB[33], 8'h03);
            checkOutput("t1_b34", logB[34], 8'h09);
            checkOutput("t1_b35", logB[35], 8'h07);
            checkOutput("t1_b38", logB[38], 8'h02);
`ifdef FRAME_PACK_CSUM_EN
            checkOutput("t1_csum", logB[39], 8'hAE);
`endif
            checkOutput("t1_span", 8'(logCyc[PKT_LEN - 1] - logCyc[0]), 8'(PKT_LEN - 1));
        end

        // Last frame write and SortValid in the same cycle.
        logB.delete();
        setSort(4'd5, 6'd17, 4'd2, 6'd11, 4'd9, 6'd4);
        writeFrame(1, 1);
        checkOutput("t2_pre_valid", 8'(OutValid), 8'h00);
        tick();
        checkOutput("t2_valid", 8'(OutValid), 8'h01);
        checkOutput("t2_hdr", OutData, 8'hA5);
        checkOutput("t2_busy", 8'(Busy), 8'h01);
        waitPacket(0);
        checkOutput("t2_len", 8'(logB.size()), 8'(PKT_LEN));

        // Ready toggling 1-0-0-1.
        readyMode = 1;
        logB.delete();
        writeFrame(0, 0);
        setSort(4'd3, 6'd9, 4'd7, 6'd5, 4'd1, 6'd2);
        applyStimulus(1'b0, 6'd0, 4'd0, 1'b1);
        waitPacket(0);
        checkOutput("t3_len", 8'(logB.size()), 8'(PKT_LEN));
        if (logB.size() == PKT_LEN) begin
            checkOutput("t3_b17", logB[17], 8'h10);
            checkOutput("t3_b37", logB[37], 8'h01);
        end

        // Dropped inputs during FRAME.
        readyMode = 0;
        logB.delete();
        writeFrame(0, 0);
        applyStimulus(1'b0, 6'd0, 4'd0, 1'b1);
        tick(); tick(); tick();
        ovCount = 0;
        setSort(4'd15, 6'd63, 4'd15, 6'd63, 4'd15, 6'd63);
        applyStimulus(1'b1, 6'd5, 4'hF, 1'b0);
        tick();
        applyStimulus(1'b0, 6'd0, 4'd0, 1'b1);
        waitPacket(0);
        checkOutput("t4_overruns", 8'(ovCount), 8'd2);
        if (logB.size() == PKT_LEN) begin
            checkOutput("t4_b3", logB[3], 8'h54);
            checkOutput("t4_b33", logB[33], 8'h03);
            checkOutput("t4_b34", logB[34], 8'h09);
        end

        // Reset after byte 10 transfers, then a fresh packet.
        logB.delete();
        setSort(4'd3, 6'd9, 4'd7, 6'd5, 4'd1, 6'd2);
        writeFrame(0, 0);
        applyStimulus(1'b0, 6'd0, 4'd0, 1'b1);
        for (int i = 0; i < 100 && logB.size() < 11; i++) tick();
        checkOutput("t5_reached_b10", 8'(logB.size()), 8'd11);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("t5_valid", 8'(OutValid), 8'h00);
        checkOutput("t5_busy", 8'(Busy), 8'h00);
        logB.delete();
        readyMode = 2;
        setSort(4'($urandom_range(0, 15)), 6'($urandom_range(0, 63)), 4'($urandom_range(0, 15)),
                6'($urandom_range(0, 63)), 4'($urandom_range(0, 15)), 6'($urandom_range(0, 63)));
        writeFrame(1, 0);
        applyStimulus(1'b0, 6'd0, 4'd0, 1'b1);
        waitPacket(0);
        checkOutput("t5_len", 8'(logB.size()), 8'(PKT_LEN));

        // Randomised packets with random stalls, overwrites and dropped writes.
        for (int it = 0; it < 4; it++) begin
            for (int j = 0; j < 8; j++)
                applyStimulus(1'b1, 6'($urandom_range(0, 62)), 4'($urandom_range(0, 15)), 1'b0);
            setSort(4'($urandom_range(0, 15)), 6'($urandom_range(0, 63)), 4'($urandom_range(0, 15)),
                    6'($urandom_range(0, 63)), 4'($urandom_range(0, 15)), 6'($urandom_range(0, 63)));
            applyStimulus(1'b0, 6'd0, 4'd0, 1'b1);
            writeFrame(1, it[0]);
            waitPacket(1);
        end

        tick(); tick();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
